// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter checker: FSM state encodings and default
// widths also used by the counter testbenches.
package counter_chk_defs;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam int unsigned CHK_W_DEFAULT      = 32;
  localparam int unsigned CHK_LOCK_N_DEFAULT = 4;
  localparam int unsigned CHK_ECW_DEFAULT    = 16;

  // Width of a counter able to hold 0..n inclusive, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/counter_checker_gray2bin.sv
// Purely combinational Gray-to-binary decoder: each binary bit is the XOR of
// the Gray bit at that position and all Gray bits above it.
module gray2bin #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  always_comb begin
    b = '0;
    for (int unsigned i = 0; i < W; i++) begin
      b[i] = ^(g >> i);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Receiving-end monitor for a free-running binary or Gray counter: predicts the
// next value, tracks lock, flags sequence errors and wraps, captures first error.
module counter_checker
  import counter_chk_defs::*;
#(
  parameter int unsigned W      = CHK_W_DEFAULT,
  parameter int unsigned GRAY   = 0,
  parameter int unsigned LOCK_N = CHK_LOCK_N_DEFAULT,
  parameter int unsigned ECW    = CHK_ECW_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   q_in,
  input  logic           q_valid,
  output logic           locked,
  output logic           err,
  output logic           wrap,
  output logic [ECW-1:0] err_count,
  output logic [W-1:0]   first_exp,
  output logic [W-1:0]   first_obs,
  output logic           first_valid
);

  localparam int unsigned GCW = cnt_width(LOCK_N);

  logic [W-1:0] dec;
  logic [W-1:0] exp_val;
  logic         match;

  generate
    if (GRAY != 0) begin : g_gray
      gray2bin #(.W(W)) u_gray2bin (
        .g (q_in),
        .b (dec)
      );
    end else begin : g_bin
      assign dec = q_in;
    end
  endgenerate

  chk_state_e     state_q,       state_d;
  logic [W-1:0]   ref_q,         ref_d;
  logic [GCW-1:0] good_cnt_q,    good_cnt_d;
  logic [ECW-1:0] err_count_q,   err_count_d;
  logic [W-1:0]   first_exp_q,   first_exp_d;
  logic [W-1:0]   first_obs_q,   first_obs_d;
  logic           first_valid_q, first_valid_d;
  logic           locked_q,      locked_d;
  logic           err_q,         err_d;
  logic           wrap_q,        wrap_d;

  assign exp_val = ref_q + W'(1);
  assign match   = (dec == exp_val);

  always_comb begin
    state_d       = state_q;
    ref_d         = ref_q;
    good_cnt_d    = good_cnt_q;
    err_count_d   = err_count_q;
    first_exp_d   = first_exp_q;
    first_obs_d   = first_obs_q;
    first_valid_d = first_valid_q;
    err_d         = 1'b0;
    wrap_d        = 1'b0;

    if (q_valid) begin
      ref_d = dec;
      case (state_q)
        HUNT: begin
          state_d    = ACQ;
          good_cnt_d = '0;
        end
        ACQ: begin
          if (!match) begin
            good_cnt_d = '0;
          end else if (good_cnt_q == GCW'(LOCK_N - 1)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GCW'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_d = (dec == '0);
          end else begin
            err_d      = 1'b1;
            state_d    = ACQ;
            good_cnt_d = '0;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ECW'(1);
            end
            if (!first_valid_q) begin
              first_exp_d   = exp_val;
              first_obs_d   = dec;
              first_valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d    = HUNT;
          good_cnt_d = '0;
        end
      endcase
    end

    // locked follows the state being entered so it appears with the same latency as err/wrap
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      ref_q         <= '0;
      good_cnt_q    <= '0;
      err_count_q   <= '0;
      first_exp_q   <= '0;
      first_obs_q   <= '0;
      first_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_q         <= ref_d;
      good_cnt_q    <= good_cnt_d;
      err_count_q   <= err_count_d;
      first_exp_q   <= first_exp_d;
      first_obs_q   <= first_obs_d;
      first_valid_q <= first_valid_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      wrap_q        <= wrap_d;
    end
  end

  assign locked      = locked_q;
  assign err         = err_q;
  assign wrap        = wrap_q;
  assign err_count   = err_count_q;
  assign first_exp   = first_exp_q;
  assign first_obs   = first_obs_q;
  assign first_valid = first_valid_q;

endmodule
